reg_wb_buffer: RTL
==================

Name: reg_wb_buffer

Overview:
- Write-back buffer on the initiator side of the register-file write port.
- Accepts write requests (address, data) from the execute/load path over a valid/ready handshake and queues them in a small FIFO.
- Drains one entry per cycle onto Reg_Write/W_Addr/W_Data.
- Provides forwarding lookups so decode reads see data for writes still pending in the buffer.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- AW, 5, register address width.
- DW, 32, register data width.

Ports:
- clk_Regs  input  1  clock; same clock as the register file.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  write request valid.
- in_ready  output  1  buffer can accept the request this cycle.
- in_addr  input  AW  destination register of the request.
- in_data  input  DW  write data of the request.
- drain_stall  input  1  when 1, the head entry is held and not written.
- Reg_Write  output  1  register-file write enable.
- W_Addr  output  AW  register-file write address.
- W_Data  output  DW  register-file write data.
- q_addr_A  input  AW  forwarding lookup address, port A.
- q_addr_B  input  AW  forwarding lookup address, port B.
- q_hit_A  output  1  a pending entry matches q_addr_A.
- q_hit_B  output  1  a pending entry matches q_addr_B.
- q_data_A  output  DW  data of the youngest entry matching q_addr_A; 0 when no hit.
- q_data_B  output  DW  data of the youngest entry matching q_addr_B; 0 when no hit.
- count  output  $clog2(DEPTH)+1  number of occupied entries.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.

Behaviour:
- Reset (async, rst_n=0): read pointer, write pointer and count go to 0; all entry valid bits cleared; empty=1, full=0, Reg_Write=0, W_Addr=0, W_Data=0, q_hit_A/B=0, q_data_A/B=0. Entry data contents are don't-care.
- Reset mid-operation discards all pending entries; nothing is written after reset deasserts until a new push occurs.
- in_ready = !full (combinational).
- Push: in_valid && in_ready at a posedge stores {in_addr, in_data} at the write pointer.
- in_addr == 0: the handshake completes (accepted) but nothing is enqueued and count is unchanged; r0 is never written.
- Drain (combinational from head): Reg_Write = !empty && !drain_stall; W_Addr/W_Data = head entry when !empty, else 0.
- Pop occurs at the same posedge the register file samples the write (Reg_Write=1).
- Latency: a request pushed into an empty buffer at edge N appears on Reg_Write/W_Addr/W_Data in cycle N+1 and is written at edge N+1 (given no stall).
- Simultaneous push and pop: count unchanged; both pointers advance.
- Push when full is impossible because in_ready=0. No same-cycle full bypass.
- Pointers wrap modulo DEPTH.
- Forwarding: combinational search of all valid entries, including the head being drained this cycle. The youngest match (nearest the write pointer) wins. Lookup address 0 never hits.
- Ordering: writes reach the register file in acceptance order. Two pending writes to the same address are both performed, oldest first.

Optional Feature:
- Macro: WB_COALESCE_EN.
- Defined:
  - A push whose in_addr (nonzero) equals the address of the youngest valid entry overwrites that entry's data instead of allocating a new entry, and count is unchanged.
  - Not permitted if that entry is the head and Reg_Write=1 this cycle; in that case the push allocates normally.
  - in_ready = !full || (coalesce match). A coalescing push is therefore accepted even when full.
- Undefined: every nonzero push allocates a new entry; in_ready = !full.

Test Plan:
- Reset then idle: rst_n low 3 cycles -> empty=1, count=0, Reg_Write=0, in_ready=1, q_hit_A=0.
- Single push addr=5 data=0xDEADBEEF into empty buffer, drain_stall=0 -> next cycle Reg_Write=1, W_Addr=5, W_Data=0xDEADBEEF; count returns to 0 after that edge.
- drain_stall=1 while pushing 4 writes (addrs 1,2,3,4) -> full=1, in_ready=0, Reg_Write=0. Release stall -> writes to 1,2,3,4 in order on 4 consecutive cycles.
- Forwarding: push addr=7 data=0x11, then addr=7 data=0x22 with stall=1 -> q_addr_A=7 gives q_hit_A=1, q_data_A=0x22; q_addr_B=0 gives q_hit_B=0.
- Push addr=0 data=0xFFFFFFFF -> accepted (in_ready=1), count stays 0, Reg_Write never asserts.
- Assert rst_n=0 with 3 entries pending, then release -> count=0, Reg_Write=0, no writes issued. With WB_COALESCE_EN: full buffer, youngest addr=9, push addr=9 data=0x33 -> accepted, count stays 4, q_data_A (q_addr_A=9)=0x33.

Source files
------------

// File: rtl/reg_wb_buffer.sv
// Write-back buffer in front of the register-file write port: queues writes, drains one per
// cycle and forwards pending data to decode. Optional macro WB_COALESCE_EN merges repeat writes.
module reg_wb_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input  logic                      clk_Regs,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [AW-1:0]             in_addr,
    input  logic [DW-1:0]             in_data,
    input  logic                      drain_stall,
    output logic                      Reg_Write,
    output logic [AW-1:0]             W_Addr,
    output logic [DW-1:0]             W_Data,
    input  logic [AW-1:0]             q_addr_A,
    input  logic [AW-1:0]             q_addr_B,
    output logic                      q_hit_A,
    output logic                      q_hit_B,
    output logic [DW-1:0]             q_data_A,
    output logic [DW-1:0]             q_data_B,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      empty,
    output logic                      full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [AW-1:0]    addr_q [DEPTH];
    logic [AW-1:0]    addr_d [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DW-1:0]    data_d [DEPTH];

    logic [PW-1:0]    youngest;
    logic [PW-1:0]    fwd_idx;
    logic             pop;
    logic             coalesce;
    logic             accept;
    logic             alloc;

    always_comb begin
        youngest  = wr_ptr_q - PW'(1);
        empty     = (count_q == '0);
        full      = (count_q == CW'(DEPTH));
        count     = count_q;
        Reg_Write = !empty && !drain_stall;
        pop       = Reg_Write;
        W_Addr    = empty ? '0 : addr_q[rd_ptr_q];
        W_Data    = empty ? '0 : data_q[rd_ptr_q];
`ifdef WB_COALESCE_EN
        // Merging into the head is unsafe once the register file is already sampling it.
        coalesce  = in_valid && (in_addr != '0) && !empty && valid_q[youngest] &&
                    (addr_q[youngest] == in_addr) && !((youngest == rd_ptr_q) && pop);
`else
        coalesce  = 1'b0;
`endif
        in_ready  = !full || coalesce;
        accept    = in_valid && in_ready;
        alloc     = accept && (in_addr != '0) && !coalesce;
    end

    always_comb begin
        rd_ptr_d = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = alloc ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d  = count_q + CW'(alloc) - CW'(pop);
        valid_d  = valid_q;
        addr_d   = addr_q;
        data_d   = data_q;
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
        end
        if (alloc) begin
            valid_d[wr_ptr_q] = 1'b1;
            addr_d[wr_ptr_q]  = in_addr;
            data_d[wr_ptr_q]  = in_data;
        end
        if (coalesce) begin
            data_d[youngest] = in_data;
        end
    end

    // Scan oldest to youngest so the last match, the youngest, wins.
    always_comb begin
        q_hit_A  = 1'b0;
        q_hit_B  = 1'b0;
        q_data_A = '0;
        q_data_B = '0;
        fwd_idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PW'(i);
            if (valid_q[fwd_idx] && (q_addr_A != '0) && (addr_q[fwd_idx] == q_addr_A)) begin
                q_hit_A  = 1'b1;
                q_data_A = data_q[fwd_idx];
            end
            if (valid_q[fwd_idx] && (q_addr_B != '0) && (addr_q[fwd_idx] == q_addr_B)) begin
                q_hit_B  = 1'b1;
                q_data_B = data_q[fwd_idx];
            end
        end
    end

    always_ff @(posedge clk_Regs or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Entry payload needs no reset; every use is qualified by valid_q or count_q.
    always_ff @(posedge clk_Regs) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

endmodule
